// File: rtl/uart_bus_master_pkg.sv
// Shared constants, FSM state types and bus payload for the UART debug bus master.
package uart_bus_master_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 271;
  localparam int unsigned DEF_BUS_TIMEOUT  = 1024;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS_REQ,
    ST_BUS_RVALID,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Payload presented on the bus while req is high.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  // Build a full-word request payload.
  function automatic bus_req_t make_req(input logic we, input logic [31:0] addr,
                                        input logic [31:0] wdata);
    bus_req_t r;
    r.we    = we;
    r.be    = 4'hF;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/uart_bus_master_if.sv
// CPU-side data/control bus between the debug master and the arbiter/slave.
interface uart_bus_master_if;

  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer; ready also rises in the final stop-bit cycle so bytes chain without a gap.
module uart_byte_tx
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       ready_c_o,
  output logic       tx_o
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  logic [BAUD_W-1:0] cnt_q;
  logic [3:0]        bit_q;
  logic [8:0]        shift_q;
  logic              busy_q;
  logic              tx_q;

  assign ready_c_o = !busy_q || ((bit_q == 4'd9) && (cnt_q == BAUD_MAX));
  assign tx_o      = tx_q;

  // Bit sequencer: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else if (start_i && ready_c_o) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= {1'b1, data_i};
      busy_q  <= 1'b1;
      tx_q    <= 1'b0;
    end else if (busy_q) begin
      if (cnt_q == BAUD_MAX) begin
        cnt_q <= '0;
        if (bit_q == 4'd9) begin
          busy_q <= 1'b0;
          tx_q   <= 1'b1;
        end else begin
          tx_q    <= shift_q[0];
          shift_q <= {1'b1, shift_q[8:1]};
          bit_q   <= bit_q + 4'd1;
        end
      end else begin
        cnt_q <= cnt_q + BAUD_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART command bridge: decodes 'W'/'R' frames into single bus transactions and replies over TX.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned BUS_TIMEOUT  = DEF_BUS_TIMEOUT
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                RX,
  output logic                TX,
  uart_bus_master_if.master   bus,
  output logic                busy,
  output logic                frm_err
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] RX_HALF  = BAUD_W'(CLKS_PER_BIT / 2);
  localparam int unsigned TMO_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(BUS_TIMEOUT - 1);

  // RX deserializer state
  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e         rx_state_q;
  logic [BAUD_W-1:0] rx_cnt_q;
  logic [2:0]        rx_bit_q;
  logic [7:0]        rx_shift_q;
  logic              frm_err_q;
  logic              rx_done_c;
  logic              frm_err_c;

  // Command FSM state
  state_e            state_q;
  logic              busy_q;
  logic              is_wr_q;
  logic [1:0]        byte_cnt_q;
  logic [31:0]       cmd_addr_q;
  logic [23:0]       cmd_data_q;
  logic              req_q;
  bus_req_t          bus_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [39:0]       resp_buf_q;
  logic [2:0]        resp_left_q;

  logic              tx_ready_c;
  logic              tx_start_c;

  assign busy      = busy_q;
  assign frm_err   = frm_err_q;
  assign bus.req   = req_q;
  assign bus.we    = bus_q.we;
  assign bus.be    = bus_q.be;
  assign bus.addr  = bus_q.addr;
  assign bus.wdata = bus_q.wdata;

  // Stop-bit sample outcomes, seen by the command FSM on the same edge.
  assign rx_done_c = (rx_state_q == RX_STOP) && (rx_cnt_q == BAUD_MAX) && rx_sync_q;
  assign frm_err_c = (rx_state_q == RX_STOP) && (rx_cnt_q == BAUD_MAX) && !rx_sync_q;

  assign tx_start_c = (state_q == ST_RESP) && (resp_left_q != 3'd0) && tx_ready_c;

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Frame receiver: start-bit recheck at half bit, mid-bit data and stop sampling.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      frm_err_q  <= 1'b0;
    end else begin
      frm_err_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_prev_q && !rx_sync_q) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_q == RX_HALF) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + BAUD_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BAUD_MAX) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + BAUD_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BAUD_MAX) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            frm_err_q  <= !rx_sync_q;
          end else begin
            rx_cnt_q <= rx_cnt_q + BAUD_W'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Command FSM: collects fields, drives the bus request, then queues the response bytes.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      is_wr_q     <= 1'b0;
      byte_cnt_q  <= '0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      req_q       <= 1'b0;
      bus_q       <= '0;
      tmo_q       <= '0;
      resp_buf_q  <= '0;
      resp_left_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_done_c && ((rx_shift_q == OP_WR) || (rx_shift_q == OP_RD))) begin
            is_wr_q    <= (rx_shift_q == OP_WR);
            byte_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (frm_err_c) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (rx_done_c) begin
            cmd_addr_q <= {cmd_addr_q[23:0], rx_shift_q};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              if (is_wr_q) begin
                state_q <= ST_DATA;
              end else begin
                req_q   <= 1'b1;
                bus_q   <= make_req(1'b0, {cmd_addr_q[23:0], rx_shift_q}, 32'h0);
                tmo_q   <= '0;
                state_q <= ST_BUS_REQ;
              end
            end
          end
        end
        ST_DATA: begin
          if (frm_err_c) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (rx_done_c) begin
            cmd_data_q <= {cmd_data_q[15:0], rx_shift_q};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              req_q   <= 1'b1;
              bus_q   <= make_req(1'b1, cmd_addr_q, {cmd_data_q, rx_shift_q});
              tmo_q   <= '0;
              state_q <= ST_BUS_REQ;
            end
          end
        end
        ST_BUS_REQ: begin
          if (bus.gnt) begin
            req_q <= 1'b0;
            bus_q <= '0;
            tmo_q <= '0;
            if (is_wr_q) begin
              resp_buf_q  <= {RSP_OK, 32'h0};
              resp_left_q <= 3'd1;
              state_q     <= ST_RESP;
            end else begin
              state_q <= ST_BUS_RVALID;
            end
          end else if (tmo_q == TMO_MAX) begin
            req_q       <= 1'b0;
            bus_q       <= '0;
            resp_buf_q  <= {RSP_ERR, 32'h0};
            resp_left_q <= 3'd1;
            state_q     <= ST_RESP;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        ST_BUS_RVALID: begin
          if (bus.rvalid) begin
            resp_buf_q  <= {RSP_OK, bus.rdata};
            resp_left_q <= 3'd5;
            state_q     <= ST_RESP;
          end else if (tmo_q == TMO_MAX) begin
            resp_buf_q  <= {RSP_ERR, 32'h0};
            resp_left_q <= 3'd1;
            state_q     <= ST_RESP;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        ST_RESP: begin
          if (tx_start_c) begin
            resp_buf_q  <= {resp_buf_q[31:0], 8'h00};
            resp_left_q <= resp_left_q - 3'd1;
          end else if ((resp_left_q == 3'd0) && tx_ready_c) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .start_i   (tx_start_c),
    .data_i    (resp_buf_q[39:32]),
    .ready_c_o (tx_ready_c),
    .tx_o      (TX)
  );

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: stimulus pushes expected bus requests and TX bytes,
// independent monitors pop and compare when the DUT presents them.
module tb_uart_bus_master;
  import uart_bus_master_pkg::*;

  localparam int unsigned CPB = 16;
  localparam int unsigned TMO = 1024;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_req_t;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic tx;
  logic busy;
  logic frm_err;

  uart_bus_master_if bus_if ();

  uart_bus_master #(
    .CLKS_PER_BIT(CPB),
    .BUS_TIMEOUT (TMO)
  ) dut (
    .Clk     (clk),
    .Rst     (rst),
    .RX      (rx),
    .TX      (tx),
    .bus     (bus_if.master),
    .busy    (busy),
    .frm_err (frm_err)
  );

  always #5 clk = ~clk;

  exp_req_t    exp_req[$];
  logic [7:0]  exp_tx[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          gnt_mode = 0;   // >=0: grant delay, -1: never (timeout), -2: never (reset test)
  logic [31:0] rd_val = '0;
  int          frm_cnt = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(CPB);
    end
    rx = stop;
    cyc(CPB);
    rx = 1'b1;
    cyc(2);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_tx.size() != 0 || busy !== 1'b0) && n < 20000) begin
      cyc(1);
      n++;
    end
    check({name, "_done"}, 80'(n < 20000), 80'(1));
    cyc(4);
  endtask

  // Bus slave model and request checker.
  initial begin : bus_mon
    exp_req_t e;
    int n;
    bus_if.gnt    = 1'b0;
    bus_if.rvalid = 1'b0;
    bus_if.rdata  = '0;
    forever begin
      cyc(1);
      if (bus_if.req === 1'b1) begin
        if (exp_req.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL req_unexpected: got addr %0h expected no request at %0t", bus_if.addr, $time);
          n = 0;
          while (bus_if.req === 1'b1 && n < 5000) begin cyc(1); n++; end
        end else begin
          e = exp_req.pop_front();
          check("req_fields", 80'({bus_if.we, bus_if.be, bus_if.addr}), 80'({e.we, 4'hF, e.addr}));
          if (e.we) check("req_wdata", 80'(bus_if.wdata), 80'(e.wdata));
          if (gnt_mode >= 0) begin
            cyc(gnt_mode);
            check("req_hold", 80'({bus_if.req, bus_if.we, bus_if.be, bus_if.addr}),
                  80'({1'b1, e.we, 4'hF, e.addr}));
            bus_if.gnt = 1'b1;
            if (!e.we) begin
              bus_if.rvalid = 1'b1;
              bus_if.rdata  = ~rd_val;
            end
            cyc(1);
            bus_if.gnt    = 1'b0;
            bus_if.rvalid = 1'b0;
            check("req_release", 80'({bus_if.req, bus_if.we, bus_if.be, bus_if.addr, bus_if.wdata}), 80'(0));
            if (!e.we) begin
              cyc(1);
              bus_if.rvalid = 1'b1;
              bus_if.rdata  = rd_val;
              cyc(1);
              bus_if.rvalid = 1'b0;
              bus_if.rdata  = '0;
            end
          end else if (gnt_mode == -1) begin
            n = 0;
            while (bus_if.req === 1'b1 && n < int'(TMO) + 100) begin cyc(1); n++; end
            check("req_timeout_cycles", 80'(n), 80'(TMO));
            check("req_release_tmo", 80'({bus_if.req, bus_if.we, bus_if.be, bus_if.addr}), 80'(0));
          end else begin
            n = 0;
            while (bus_if.req === 1'b1 && n < 5000) begin cyc(1); n++; end
          end
        end
      end
    end
  end

  // Serial decoder on TX; also checks back-to-back framing and busy release.
  initial begin : tx_mon
    logic [7:0] b;
    logic more;
    forever begin
      @(negedge tx);
      more = 1'b1;
      while (more) begin
        repeat (CPB / 2) @(posedge clk);
        #1;
        check("tx_start_bit", 80'(tx), 80'(0));
        for (int i = 0; i < 8; i++) begin
          cyc(CPB);
          b[i] = tx;
        end
        cyc(CPB);
        check("tx_stop_bit", 80'(tx), 80'(1));
        if (exp_tx.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_unexpected: got %0h expected no byte at %0t", b, $time);
          more = 1'b0;
        end else begin
          check("tx_byte", 80'(b), 80'(exp_tx.pop_front()));
          more = (exp_tx.size() != 0);
          if (more) begin
            cyc(CPB - CPB / 2);
            check("tx_back_to_back", 80'(tx), 80'(0));
            if (tx !== 1'b0) more = 1'b0;
          end else begin
            cyc(CPB - CPB / 2 - 1);
            check("busy_before_stop_end", 80'(busy), 80'(1));
            cyc(1);
            check("busy_at_stop_end", 80'(busy), 80'(0));
          end
        end
      end
    end
  end

  // Count frm_err cycles so a stretched pulse shows up as a count above one.
  initial begin : frm_mon
    forever begin
      @(negedge clk);
      if (frm_err === 1'b1) frm_cnt++;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin : stim
    int n;
    rst = 1'b1;
    rx  = 1'b1;
    cyc(3);
    check("reset_state",
          80'({tx, busy, frm_err, bus_if.req, bus_if.we, bus_if.be, bus_if.addr, bus_if.wdata}),
          80'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0}));
    rst = 1'b0;
    cyc(5);

    // Write with grant after 3 cycles.
    gnt_mode = 3;
    exp_req.push_back('{we: 1'b1, addr: 32'h0000_0001, wdata: 32'hDEAD_BEEF});
    exp_tx.push_back(8'h4B);
    send_byte(OP_WR, 1'b1);
    check("busy_after_opcode", 80'(busy), 80'(1));
    send_word(32'h0000_0001);
    send_word(32'hDEAD_BEEF);
    wait_idle("write");

    // Read, grant after 1 cycle, rvalid two cycles after grant.
    gnt_mode = 1;
    rd_val = 32'h1234_5678;
    exp_req.push_back('{we: 1'b0, addr: 32'h0000_0002, wdata: 32'h0});
    exp_tx.push_back(8'h4B); exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h56); exp_tx.push_back(8'h78);
    send_byte(OP_RD, 1'b1);
    send_word(32'h0000_0002);
    wait_idle("read");

    // Grant never comes: error response, then a normal read.
    gnt_mode = -1;
    exp_req.push_back('{we: 1'b0, addr: 32'h0000_0010, wdata: 32'h0});
    exp_tx.push_back(8'h45);
    send_byte(OP_RD, 1'b1);
    send_word(32'h0000_0010);
    wait_idle("timeout");
    gnt_mode = 1;
    rd_val = 32'hCAFE_F00D;
    exp_req.push_back('{we: 1'b0, addr: 32'h0000_0014, wdata: 32'h0});
    exp_tx.push_back(8'h4B); exp_tx.push_back(8'hCA); exp_tx.push_back(8'hFE);
    exp_tx.push_back(8'hF0); exp_tx.push_back(8'h0D);
    send_byte(OP_RD, 1'b1);
    send_word(32'h0000_0014);
    wait_idle("read_after_timeout");

    // Framing error inside the address field.
    frm_cnt = 0;
    send_byte(OP_WR, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h12, 1'b0);
    cyc(2);
    check("frm_err_pulse_cycles", 80'(frm_cnt), 80'(1));
    check("busy_after_frm_err", 80'(busy), 80'(0));
    gnt_mode = 0;
    exp_req.push_back('{we: 1'b1, addr: 32'h0000_0020, wdata: 32'h0102_0304});
    exp_tx.push_back(8'h4B);
    send_byte(OP_WR, 1'b1);
    send_word(32'h0000_0020);
    send_word(32'h0102_0304);
    wait_idle("write_after_frm_err");

    // Unknown opcode ignored, then a read with a byte injected during the response.
    gnt_mode = 2;
    rd_val = 32'hA5A5_5A5A;
    send_byte(8'h00, 1'b1);
    check("busy_after_bad_opcode", 80'(busy), 80'(0));
    exp_req.push_back('{we: 1'b0, addr: 32'h0000_0044, wdata: 32'h0});
    exp_tx.push_back(8'h4B); exp_tx.push_back(8'hA5); exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'h5A); exp_tx.push_back(8'h5A);
    send_byte(OP_RD, 1'b1);
    send_word(32'h0000_0044);
    n = 0;
    while (exp_tx.size() > 3 && n < 5000) begin cyc(1); n++; end
    check("resp_in_progress", 80'(n < 5000), 80'(1));
    send_byte(OP_RD, 1'b1);
    wait_idle("read_with_inject");
    cyc(CPB * 12);
    check("busy_after_inject", 80'(busy), 80'(0));

    // Reset while the request is pending.
    gnt_mode = -2;
    exp_req.push_back('{we: 1'b1, addr: 32'h0000_0030, wdata: 32'h55AA_55AA});
    send_byte(OP_WR, 1'b1);
    send_word(32'h0000_0030);
    send_word(32'h55AA_55AA);
    n = 0;
    while (bus_if.req !== 1'b1 && n < 2000) begin cyc(1); n++; end
    check("req_before_reset", 80'(bus_if.req), 80'(1));
    cyc(5);
    rst = 1'b1;
    cyc(1);
    check("reset_mid_bus",
          80'({bus_if.req, bus_if.we, bus_if.be, bus_if.addr, bus_if.wdata, tx, busy}),
          80'({1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0}));
    rst = 1'b0;
    cyc(5);

    // Normal read after reset.
    gnt_mode = 0;
    rd_val = 32'h0BAD_F00D;
    exp_req.push_back('{we: 1'b0, addr: 32'h0000_0008, wdata: 32'h0});
    exp_tx.push_back(8'h4B); exp_tx.push_back(8'h0B); exp_tx.push_back(8'hAD);
    exp_tx.push_back(8'hF0); exp_tx.push_back(8'h0D);
    send_byte(OP_RD, 1'b1);
    send_word(32'h0000_0008);
    wait_idle("read_after_reset");

    check("exp_req_drained", 80'(exp_req.size()), 80'(0));
    check("exp_tx_drained", 80'(exp_tx.size()), 80'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

Serial debug bridge that turns command bytes arriving on a UART RX line (8N1, fixed baud) into 32-bit transactions on the CPU-side data/control bus (req/we/be/addr/wdata out; gnt/rvalid/rdata in). It then returns status and read data on a UART TX line. It sits beside the CPU as a second bus initiator, in front of the bus arbiter, and lets an external host peek and poke peripherals such as the UART block without firmware.

## Interface
- CLKS_PER_BIT, 271: clock cycles per serial bit (31.25 MHz / 115200).
- BUS_TIMEOUT, 1024: maximum cycles to wait for gnt, then for rvalid.
- Clk  in  1  system clock; all logic is on the rising edge.
- Rst  in  1  reset; synchronous, active-high.
- RX  in  1  serial input, idle high; asynchronous to Clk.
- TX  out  1  serial output, idle high.
- req  out  1  bus request.
- we  out  1  write enable.
- be  out  4  byte enables.
- addr  out  32  word address.
- wdata  out  32  write data.
- gnt  in  1  bus grant.
- rvalid  in  1  read data valid.
- rdata  in  32  read data.
- busy  out  1  high from the first opcode byte until the last response stop bit.
- frm_err  out  1  one-cycle pulse on an RX framing error.

## Operation
- **RX path**
  - RX goes through a 2-flop synchronizer.
  - A falling edge in idle starts a frame. The start bit is re-sampled at CLKS_PER_BIT/2; if it is high, the frame is aborted.
  - Data bits are sampled mid-bit, LSB first. The stop bit is sampled mid-bit; if it is 0, frm_err pulses, the byte is discarded and the command FSM returns to IDLE.
- **Command format** (all multi-byte fields MSB first)
  - 0x57 ('W'): addr[4] then data[4].
  - 0x52 ('R'): addr[4].
  - Any other opcode byte in IDLE is ignored.
- **FSM states**: IDLE, ADDR, DATA, BUS_REQ, BUS_RVALID, RESP.
  - IDLE -> ADDR on a valid opcode.
  - ADDR -> DATA (W) or BUS_REQ (R) after 4 bytes.
  - DATA -> BUS_REQ after 4 bytes.
  - BUS_REQ -> RESP (W) or BUS_RVALID (R) once gnt is sampled.
  - BUS_RVALID -> RESP once rvalid is sampled.
  - RESP -> IDLE after the last byte's stop bit.
- **Responses**
  - Write: 0x4B ('K').
  - Read: 0x4B followed by rdata[31:24], [23:16], [15:8], [7:0].
  - Timeout in BUS_REQ or BUS_RVALID: 0x45 ('E') only.
- be is always 4'b1111 during a request.
- Bytes received in BUS_REQ, BUS_RVALID or RESP are discarded; they are not queued.

## Timing
- **Reset values**: TX=1, req=0, we=0, be=0, addr=0, wdata=0, busy=0, frm_err=0. The FSM goes to IDLE, both serial engines go idle and all counters clear. Reset asserted mid-frame or mid-transaction aborts it immediately; TX returns to 1 on the next edge.
- **Request launch**: req, we, be, addr and wdata are asserted together on the cycle after the final command byte's stop-bit sample.
- **Request hold**: they stay stable until gnt=1 is sampled at a rising edge.
- **Request release**: on the next cycle req=0, we=0, be=0, addr=0, wdata=0.
- **Read capture**: rdata is captured on the first edge with rvalid=1 after the grant. An rvalid in the grant cycle itself is ignored.
- **Timeout counter**: counts from req assertion. If it reaches BUS_TIMEOUT without gnt, req drops and 'E' is sent. The counter restarts after the grant for the rvalid wait, with the same limit.
- **Response start**: the first TX start bit begins the cycle after RESP is entered.
- **TX framing**: 10 bits × CLKS_PER_BIT per byte (2710 cycles at default). Response bytes are sent back-to-back with no idle gap. busy clears on the cycle the last stop bit ends.
- **Baud counter**: wraps from CLKS_PER_BIT-1 to 0. Its width is $clog2(CLKS_PER_BIT).

## Structure
- Package uart_bus_master_pkg holds:
  - OP_WR=8'h57, OP_RD=8'h52, RSP_OK=8'h4B, RSP_ERR=8'h45;
  - the FSM state enum;
  - the default CLKS_PER_BIT.
- Sub-module uart_byte_tx: a serializer with a start/ready handshake (start accepted only when ready). It is instantiated once.
- The RX deserializer and the command FSM live in the top module.

## Test plan
- Send 'W',00,00,00,01,DE,AD,BE,EF with gnt after 3 cycles -> one request with we=1, addr=0x1, wdata=0xDEADBEEF, be=F; then TX sends 0x4B.
- Send 'R',00,00,00,02 with gnt after 1 cycle and rvalid with rdata=0x12345678 two cycles later -> TX sends 4B,12,34,56,78 back-to-back.
- Hold gnt=0 for a read -> req drops after 1024 cycles and TX sends 0x45; a following 'R' command works normally.
- Send a byte whose stop bit is 0 in the middle of the address field -> frm_err pulses for 1 cycle, no bus request occurs, and the next full 'W' command succeeds.
- Send opcode 0x00 followed by a full 'R' command -> 0x00 is ignored and the read completes. Also, a byte injected during RESP is dropped without corrupting the response.
- Assert Rst while BUS_REQ is active -> req=0 and TX=1 on the next edge; busy=0.
